// File: rtl/kicker_clock_delay_sequencer.sv
// IDELAYCTRL bring-up, tap-by-tap IDELAYE2 seek and coarse delay publication for the
// kicker gate-driver clock path. Single sysClk domain.
module kicker_clock_delay_sequencer #(
  parameter int unsigned TAP_WIDTH     = 5,
  parameter int unsigned COARSE_WIDTH  = 12,
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned RDY_TIMEOUT   = 4096,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    sysClk,
  input  logic                    sysReset_n,
  input  logic                    sysCsrStrobe,
  input  logic [31:0]             sysGPIO_OUT,
  input  logic [TAP_WIDTH-1:0]    tapCount,
  input  logic                    idelayCtrlRdy,
  output logic                    idelayCtrlReset,
  output logic                    idelayCE,
  output logic                    idelayINC,
  output logic [COARSE_WIDTH-1:0] coarseDelay,
  output logic                    coarseDelayToggle,
  output logic                    busy,
  output logic [31:0]             sysStatus
);

  localparam int unsigned CntMax0 = (RDY_TIMEOUT > RESET_CYCLES) ? RDY_TIMEOUT : RESET_CYCLES;
  localparam int unsigned CntMax  = (CntMax0 > SETTLE_CYCLES) ? CntMax0 : SETTLE_CYCLES;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCtrlReset = 3'd1,
    StWaitRdy   = 3'd2,
    StCheck     = 3'd3,
    StStep      = 3'd4,
    StSettle    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0]    target_q, target_d;
  logic [TAP_WIDTH-1:0]    expected_q, expected_d;
  logic                    dir_q, dir_d;
  logic                    rdy_to_q, rdy_to_d;
  logic                    step_err_q, step_err_d;
  logic [COARSE_WIDTH-1:0] coarse_q, coarse_d;
  logic                    tog_q, tog_d;
  logic                    set_rdy_to, set_step_err;

  // CSR decode; abort masks reset and seek within the same write.
  logic csr_hit, cmd_abort, cmd_reset, cmd_seek, cmd_clear, cmd_coarse;
  assign csr_hit    = sysCsrStrobe && (sysGPIO_OUT[31:24] == 8'hFE);
  assign cmd_abort  = csr_hit && sysGPIO_OUT[21];
  assign cmd_reset  = csr_hit && sysGPIO_OUT[23] && !sysGPIO_OUT[21];
  assign cmd_seek   = csr_hit && sysGPIO_OUT[22] && !sysGPIO_OUT[23] && !sysGPIO_OUT[21];
  assign cmd_clear  = csr_hit && sysGPIO_OUT[19];
  assign cmd_coarse = csr_hit && sysGPIO_OUT[15];

  logic unused_gpio;
  assign unused_gpio = ^sysGPIO_OUT[14:12];

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_q    <= StCtrlReset;
      cnt_q      <= '0;
      target_q   <= '0;
      expected_q <= '0;
      dir_q      <= 1'b0;
      rdy_to_q   <= 1'b0;
      step_err_q <= 1'b0;
      coarse_q   <= '0;
      tog_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      expected_q <= expected_d;
      dir_q      <= dir_d;
      rdy_to_q   <= rdy_to_d;
      step_err_q <= step_err_d;
      coarse_q   <= coarse_d;
      tog_q      <= tog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    expected_d   = expected_q;
    dir_d        = dir_q;
    set_rdy_to   = 1'b0;
    set_step_err = 1'b0;
    if (cmd_abort && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (cmd_reset) begin
            state_d = StCtrlReset;
          end else if (cmd_seek) begin
            target_d = sysGPIO_OUT[16 +: TAP_WIDTH];
            state_d  = StCheck;
          end
        end
        StCtrlReset: begin
          if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
            state_d = StWaitRdy;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitRdy: begin
          if (idelayCtrlRdy) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == CntW'(RDY_TIMEOUT - 1)) begin
            set_rdy_to = 1'b1;
            state_d    = StIdle;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StCheck: begin
          // Direction follows the target, so expected never leaves 0..max tap.
          if (tapCount == target_q) begin
            state_d = StIdle;
          end else if (tapCount < target_q) begin
            dir_d      = 1'b1;
            expected_d = tapCount + TAP_WIDTH'(1);
            state_d    = StStep;
          end else begin
            dir_d      = 1'b0;
            expected_d = tapCount - TAP_WIDTH'(1);
            state_d    = StStep;
          end
        end
        StStep: begin
          state_d = StSettle;
          cnt_d   = '0;
        end
        StSettle: begin
          if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
            cnt_d = '0;
            if (tapCount == expected_q) begin
              state_d = StCheck;
            end else begin
              set_step_err = 1'b1;
              state_d      = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Flags: a set on the same edge as a clear wins.
  always_comb begin
    rdy_to_d   = rdy_to_q;
    step_err_d = step_err_q;
    if (cmd_clear) begin
      rdy_to_d   = 1'b0;
      step_err_d = 1'b0;
    end
    if (set_rdy_to) rdy_to_d = 1'b1;
    if (set_step_err) step_err_d = 1'b1;
    coarse_d = coarse_q;
    tog_d    = tog_q;
    if (cmd_coarse) begin
      coarse_d = sysGPIO_OUT[COARSE_WIDTH-1:0];
      tog_d    = ~tog_q;
    end
  end

  // Decoded from state so reset assertion forces CE low and RST high immediately.
  always_comb begin
    idelayCtrlReset   = (state_q == StCtrlReset);
    idelayCE          = (state_q == StStep);
    idelayINC         = dir_q;
    busy              = (state_q != StIdle);
    coarseDelay       = coarse_q;
    coarseDelayToggle = tog_q;
    sysStatus         = '0;
    sysStatus[31]     = busy;
    sysStatus[30]     = rdy_to_q;
    sysStatus[29]     = step_err_q;
    sysStatus[28]     = idelayCtrlRdy;
    sysStatus[27:25]  = state_q;
    sysStatus[24:20]  = 5'(target_q);
    sysStatus[19:15]  = 5'(tapCount);
    sysStatus[11:0]   = 12'(coarse_q);
  end

endmodule
